// File: rtl/imm_gen_pkg.sv
// ============================================================================
//  Module      : imm_gen_pkg
//  Description : Shared opcodes, immediate-format encoding and XLEN check
//                for the pipelined RISC-V immediate generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_gen_pkg;

    localparam logic [6:0] c_OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] c_OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] c_OPC_JALR      = 7'b1100111;
    localparam logic [6:0] c_OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] c_OPC_STORE     = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI       = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL       = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
// ============================================================================
//  Module      : imm_decode
//  Description : Combinational RISC-V immediate extraction, format
//                classification and PC-relative target computation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] target_o,
    output fmt_e            fmt_o,
    output logic            no_imm_o
);

    logic [31:0] w_imm32;
    logic        w_use_pc;

    // Every format carries its sign in instr[31], so a 32-bit immediate is
    // built first and widened afterwards.
    always_comb begin
        w_imm32  = '0;
        w_use_pc = 1'b0;
        fmt_o    = FMT_NONE;
        no_imm_o = 1'b0;
        unique case (instr_i[6:0])
            c_OPC_LOAD, c_OPC_OP_IMM, c_OPC_OP_IMM_32, c_OPC_JALR, c_OPC_SYSTEM: begin
                fmt_o   = FMT_I;
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            c_OPC_STORE: begin
                fmt_o   = FMT_S;
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            c_OPC_BRANCH: begin
                fmt_o    = FMT_B;
                w_use_pc = 1'b1;
                w_imm32  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            end
            c_OPC_LUI: begin
                fmt_o   = FMT_U;
                w_imm32 = {instr_i[31:12], 12'b0};
            end
            c_OPC_AUIPC: begin
                fmt_o    = FMT_U;
                w_use_pc = 1'b1;
                w_imm32  = {instr_i[31:12], 12'b0};
            end
            c_OPC_JAL: begin
                fmt_o    = FMT_J;
                w_use_pc = 1'b1;
                w_imm32  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            end
            default: begin
                no_imm_o = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 32) begin : g_xlen32
            assign imm_o = w_imm32;
        end else begin : g_xlen_wide
            assign imm_o = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end
    endgenerate

    assign target_o = w_use_pc ? (pc_i + imm_o) : '0;

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Registered valid/ready wrapper around imm_decode. Define
//                IMM_GEN_SKID_EN for a 2-entry skid buffer with registered
//                in_ready; otherwise a single pipeline stage is built.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_fmt,
    output logic            out_no_imm
);

    // Entry layout, LSB first: imm, target, fmt, no_imm.
    localparam int ENT_W = 2*XLEN + 4;

    generate
        if (!xlen_legal(XLEN)) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [XLEN-1:0]  w_imm;
    logic [XLEN-1:0]  w_target;
    fmt_e             w_fmt;
    logic             w_no_imm;
    logic [ENT_W-1:0] w_ent;
    logic             w_push;
    logic             w_pop;

    logic             main_valid_q, main_valid_d;
    logic [ENT_W-1:0] main_q, main_d;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i  (in_instr),
        .pc_i     (in_pc),
        .imm_o    (w_imm),
        .target_o (w_target),
        .fmt_o    (w_fmt),
        .no_imm_o (w_no_imm)
    );

    assign w_ent  = {w_no_imm, w_fmt, w_target, w_imm};
    assign w_push = in_valid & in_ready;
    assign w_pop  = main_valid_q & out_ready;

`ifdef IMM_GEN_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [ENT_W-1:0] skid_q, skid_d;

    assign in_ready = !skid_valid_q;

    // The skid entry only fills while the main stage is stalled, so it is
    // always the younger item and drains into the main stage first.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || w_pop) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = w_push;
                if (w_push) begin
                    main_d = w_ent;
                end
            end
        end else if (w_push) begin
            skid_valid_d = 1'b1;
            skid_d       = w_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
`else
    assign in_ready = !main_valid_q | out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (w_push) begin
            main_valid_d = 1'b1;
            main_d       = w_ent;
        end else if (w_pop) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
        end
    end

    assign out_valid  = main_valid_q;
    assign out_imm    = main_q[XLEN-1:0];
    assign out_target = main_q[2*XLEN-1:XLEN];
    assign out_fmt    = main_q[2*XLEN+2:2*XLEN];
    assign out_no_imm = main_q[2*XLEN+3];

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Randomised scoreboard bench for imm_gen_pipe (XLEN 32/64).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ni;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid, out_no_imm;
    logic [31:0] out_imm, out_target;
    logic [2:0]  out_fmt;

    logic        v64, f64, ordy64, irdy64, ov64, ni64;
    logic [31:0] i64;
    logic [63:0] p64, imm64, tgt64;
    logic [2:0]  fmt64;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t held;
    bit   stall_prev = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_target(out_target), .out_fmt(out_fmt), .out_no_imm(out_no_imm)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(f64), .in_valid(v64),
        .in_ready(irdy64), .in_instr(i64), .in_pc(p64),
        .out_valid(ov64), .out_ready(ordy64), .out_imm(imm64),
        .out_target(tgt64), .out_fmt(fmt64), .out_no_imm(ni64)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the ISA bit-placement rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
        exp_t               e;
        logic signed [63:0] s;
        logic [63:0]        mask;
        bit                 rel;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        s    = '0;
        rel  = 1'b0;
        e.ni = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin e.fmt = 3'd1; s = $signed(ins[31:20]); end
            7'h23: begin e.fmt = 3'd2; s = $signed({ins[31:25], ins[11:7]}); end
            7'h63: begin e.fmt = 3'd3; rel = 1'b1;
                   s = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); end
            7'h37: begin e.fmt = 3'd4; s = $signed({ins[31:12], 12'b0}); end
            7'h17: begin e.fmt = 3'd4; rel = 1'b1; s = $signed({ins[31:12], 12'b0}); end
            7'h6F: begin e.fmt = 3'd5; rel = 1'b1;
                   s = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); end
            default: begin e.fmt = 3'd0; e.ni = 1'b1; end
        endcase
        e.imm = s & mask;
        e.tgt = rel ? ((pc + s) & mask) : 64'd0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23,
                                  7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        logic [31:0] r;
        r      = $urandom;
        r[6:0] = ops[$urandom_range(0, 10)];
        return r;
    endfunction

    // One clock of the 32-bit DUT: drive, check the scoreboard, advance.
    task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        exp_t e;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (stall_prev) begin
            check_eq("stall_imm", out_imm, held.imm);
            check_eq("stall_tgt", out_target, held.tgt);
            check_eq("stall_meta", {out_no_imm, out_fmt}, {held.ni, held.fmt});
        end
        check_eq("out_valid", out_valid, q.size() != 0);
`ifdef IMM_GEN_SKID_EN
        check_eq("in_ready", in_ready, q.size() < 2);
`else
        check_eq("in_ready", in_ready, !out_valid || ordy);
`endif
        if (out_valid && ordy && !fl && q.size() != 0) begin
            e = q.pop_front();
            check_eq("pop_imm", out_imm, e.imm);
            check_eq("pop_tgt", out_target, e.tgt);
            check_eq("pop_meta", {out_no_imm, out_fmt}, {e.ni, e.fmt});
        end
        if (fl) q.delete();
        else if (iv && in_ready) q.push_back(model(ins, {32'd0, pc}, 32));
        stall_prev = out_valid && !ordy && !fl;
        held.imm   = out_imm;
        held.tgt   = out_target;
        held.fmt   = out_fmt;
        held.ni    = out_no_imm;
        @(negedge clk);
    endtask

    task automatic direct32(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] tgt, input logic [2:0] fmt, input bit ni);
        cycle(1'b1, ins, pc, 1'b1, 1'b0);
        check_eq("dir_valid", out_valid, 1'b1);
        check_eq("dir_imm", out_imm, imm);
        check_eq("dir_tgt", out_target, tgt);
        check_eq("dir_fmt", out_fmt, fmt);
        check_eq("dir_noimm", out_no_imm, ni);
    endtask

    task automatic run64(input logic [31:0] ins, input logic [63:0] pc);
        exp_t e;
        v64 = 1'b1;
        i64 = ins;
        p64 = pc;
        @(negedge clk);
        v64 = 1'b0;
        e   = model(ins, pc, 64);
        check_eq("x64_valid", ov64, 1'b1);
        check_eq("x64_imm", imm64, e.imm);
        check_eq("x64_tgt", tgt64, e.tgt);
        check_eq("x64_meta", {ni64, fmt64}, {e.ni, e.fmt});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        v64 = 1'b0; f64 = 1'b0; ordy64 = 1'b1; i64 = '0; p64 = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_imm", out_imm, 32'd0);
        check_eq("rst_tgt", out_target, 32'd0);
        check_eq("rst_meta", {out_no_imm, out_fmt}, 4'd0);
        check_eq("rst_valid64", ov64, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", in_ready, 1'b1);

        direct32(32'hFFF00093, 32'h0,   32'hFFFFFFFF, 32'h0,   3'd1, 1'b0);
        direct32(32'h00812423, 32'h0,   32'h8,        32'h0,   3'd2, 1'b0);
        direct32(32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 32'hFC,  3'd3, 1'b0);
        direct32(32'h0080006F, 32'h200, 32'h8,        32'h208, 3'd5, 1'b0);
        direct32(32'h00008067, 32'h400, 32'h0,        32'h0,   3'd1, 1'b0);
        direct32(32'hFFFFF097, 32'h2000, 32'hFFFFF000, 32'h1000, 3'd4, 1'b0);
        direct32(32'h00000033, 32'h0,   32'h0,        32'h0,   3'd0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) cycle(1'b1, rand_instr(), $urandom, 1'b0, 1'b1);
            else cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                       $urandom_range(0, 1) == 1, 1'b0);
        end
        for (int i = 0; i < 8 && q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("drain_empty", q.size(), 0);

        cycle(1'b1, 32'h00100093, 32'h10, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 32'h14, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300093, 32'h18, 1'b0, 1'b1);
        check_eq("flush_valid", out_valid, 1'b0);
        check_eq("flush_ready", in_ready, 1'b1);
        repeat (4) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        cycle(1'b1, 32'h12345037, 32'h20, 1'b0, 1'b0);
        cycle(1'b1, 32'h00C00113, 32'h24, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 1'b0);
        check_eq("arst_imm", out_imm, 32'd0);
        check_eq("arst_tgt", out_target, 32'd0);
        check_eq("arst_meta", {out_no_imm, out_fmt}, 4'd0);
        q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_ready", in_ready, 1'b1);
        check_eq("arst_valid2", out_valid, 1'b0);

        run64(32'h800000B7, 64'h0);
        check_eq("lui64_imm", imm64, 64'hFFFFFFFF80000000);
        check_eq("lui64_tgt", tgt64, 64'h0);
        run64(32'h00001097, 64'hFFFFFFFFFFFFF000);
        check_eq("auipc64_imm", imm64, 64'h1000);
        check_eq("auipc64_tgt", tgt64, 64'h0);
        for (int i = 0; i < 30; i++) run64(rand_instr(), {$urandom, $urandom});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
